jtag_drv: RTL and testbench

- Single-clock JTAG initiator that drives TCK/TMS/TDI and samples TDO of an IEEE 1149.1 TAP, such as the HGO chip test port.
- Used on the FPGA test harness and in the chip-level bench to program and read back the HGO configuration and result registers.
- Accepts scan commands over a valid/ready interface: TAP reset, IR scan or DR scan of up to MAX_LEN bits.
- Walks the TAP from Run-Test/Idle to the shift state and back, and returns the captured TDO bits.

---
 rtl/jtag_drv.sv | 239 +++++++++++++++++++++++
 tb/tb_jtag_drv.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_drv.sv
// rtl/jtag_drv.sv - JTAG initiator driving TCK/TMS/TDI and capturing TDO for TAP reset, IR and DR scans
//
// Ports:
//   clk, rst_n           system clock, synchronous active-low reset
//   i_cmd_valid          command valid; o_cmd_ready accepts it (valid && ready)
//   i_cmd_rst            1 = TAP reset command (overrides i_cmd_ir)
//   i_cmd_ir             1 = IR scan, 0 = DR scan
//   i_cmd_len            scan length in bits (clamped to MAX_LEN)
//   i_cmd_data           TDI bits, bit 0 shifted first
//   o_rsp_valid          one-cycle completion pulse
//   o_rsp_data           captured TDO bits, bit 0 captured first; held until next accept
//   o_busy               high while a command is in flight, including the response cycle
//   o_tck, o_tms, o_tdi  JTAG outputs
//   i_tdo                JTAG TDO

module jtag_drv #(
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = 9,
    parameter int DIV     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic               i_cmd_rst,
    input  logic               i_cmd_ir,
    input  logic [LEN_W-1:0]   i_cmd_len,
    input  logic [MAX_LEN-1:0] i_cmd_data,
    output logic               o_rsp_valid,
    output logic [MAX_LEN-1:0] o_rsp_data,
    output logic               o_busy,
    output logic               o_tck,
    output logic               o_tms,
    output logic               o_tdi,
    input  logic               i_tdo
);

    // TCK index counter needs room for MAX_LEN plus the longest pre/post overhead.
    localparam int CNT_W = LEN_W + 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   idx_q, idx_d;       // index of the current TCK within the command
    logic [CNT_W-1:0]   last_q, last_d;     // index of the final TCK
    logic [LEN_W-1:0]   len_q, len_d;
    logic               rst_cmd_q, rst_cmd_d;
    logic               ir_q, ir_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] rsp_q, rsp_d;

    logic               accept;
    logic [LEN_W-1:0]   len_clamp;

    // TMS/TDI generator. It is evaluated for TCK 0 of the incoming command
    // while idle, and for the next TCK of the latched command while running,
    // so the same rules drive both the entry value and every falling edge.
    logic               g_rst;
    logic               g_ir;
    logic [CNT_W-1:0]   g_len;
    logic [MAX_LEN-1:0] g_data;
    logic [CNT_W-1:0]   g_idx;
    logic [CNT_W-1:0]   g_pre;
    logic [CNT_W-1:0]   g_k;
    logic               g_in_shift;
    logic               g_tms;
    logic               g_tdi;

    // Capture position for the TCK currently in progress.
    logic [CNT_W-1:0]   c_pre;
    logic [CNT_W-1:0]   c_k;
    logic               c_in_shift;

    assign accept    = i_cmd_valid && (state_q == S_IDLE);
    assign len_clamp = (i_cmd_len > MAX_LEN_L) ? MAX_LEN_L : i_cmd_len;

    always_comb begin
        if (state_q == S_IDLE) begin
            g_rst  = i_cmd_rst;
            g_ir   = i_cmd_ir;
            g_len  = {1'b0, len_clamp};
            g_data = i_cmd_data;
            g_idx  = '0;
        end else begin
            g_rst  = rst_cmd_q;
            g_ir   = ir_q;
            g_len  = {1'b0, len_q};
            g_data = data_q;
            g_idx  = idx_q + CNT_W'(1);
        end

        // DR scan: 1,0,0 reaches Shift-DR; IR scan: 1,1,0,0 reaches Shift-IR.
        g_pre      = g_ir ? CNT_W'(4) : CNT_W'(3);
        g_k        = g_idx - g_pre;
        g_in_shift = !g_rst && (g_idx >= g_pre) && (g_idx < g_pre + g_len);

        if (g_rst) begin
            g_tms = (g_idx < CNT_W'(5));
        end else if (g_idx < g_pre) begin
            g_tms = g_ir ? (g_idx < CNT_W'(2)) : (g_idx == '0);
        end else if (g_in_shift) begin
            g_tms = (g_k == g_len - CNT_W'(1));
        end else begin
            // Post sequence: 1 (Update) then 0 (Run-Test/Idle).
            g_tms = (g_idx == g_pre + g_len);
        end

        g_tdi = g_in_shift && (|(g_data & (MAX_LEN'(1) << g_k)));
    end

    always_comb begin
        c_pre      = ir_q ? CNT_W'(4) : CNT_W'(3);
        c_k        = idx_q - c_pre;
        c_in_shift = !rst_cmd_q && (idx_q >= c_pre) && (idx_q < c_pre + {1'b0, len_q});
    end

    always_comb begin
        state_d   = state_q;
        tck_d     = tck_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        div_d     = div_q;
        idx_d     = idx_q;
        last_d    = last_q;
        len_d     = len_q;
        rst_cmd_d = rst_cmd_q;
        ir_d      = ir_q;
        data_d    = data_q;
        rsp_d     = rsp_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rst_cmd_d = i_cmd_rst;
                    ir_d      = i_cmd_ir;
                    len_d     = len_clamp;
                    data_d    = i_cmd_data;
                    rsp_d     = '0;
                    idx_d     = '0;
                    div_d     = '0;
                    tck_d     = 1'b0;
                    last_d    = g_rst ? CNT_W'(5) : (g_pre + g_len + CNT_W'(1));
                    if (!i_cmd_rst && (len_clamp == '0)) begin
                        // Empty scan: no TCK at all, respond immediately.
                        state_d = S_RESP;
                    end else begin
                        state_d = S_RUN;
                        tms_d   = g_tms;
                        tdi_d   = g_tdi;
                    end
                end
            end

            S_RUN: begin
                // First high cycle of TCK: TDO is stable since the TAP's
                // previous falling edge.
                if (tck_q && (div_q == '0) && c_in_shift) begin
                    rsp_d = rsp_q | (MAX_LEN'(i_tdo) << c_k);
                end

                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    tck_d = ~tck_q;
                    if (tck_q) begin
                        if (idx_q == last_q) begin
                            // Final TMS is 0 and TDI is 0 already; hold them.
                            state_d = S_RESP;
                        end else begin
                            idx_d = idx_q + CNT_W'(1);
                            tms_d = g_tms;
                            tdi_d = g_tdi;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tck_q     <= 1'b0;
            tms_q     <= 1'b1;
            tdi_q     <= 1'b0;
            div_q     <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            len_q     <= '0;
            rst_cmd_q <= 1'b0;
            ir_q      <= 1'b0;
            data_q    <= '0;
            rsp_q     <= '0;
        end else begin
            state_q   <= state_d;
            tck_q     <= tck_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            len_q     <= len_d;
            rst_cmd_q <= rst_cmd_d;
            ir_q      <= ir_d;
            data_q    <= data_d;
            rsp_q     <= rsp_d;
        end
    end

    assign o_cmd_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_rsp_valid = (state_q == S_RESP);
    assign o_rsp_data  = rsp_q;
    assign o_tck       = tck_q;
    assign o_tms       = tms_q;
    assign o_tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_drv.sv
// tb/tb_jtag_drv.sv - self-checking bench for jtag_drv with a behavioural TAP device
module tb_jtag_drv;

    localparam int MAX_LEN = 256;
    localparam int LEN_W   = 9;
    localparam int DIV     = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_cmd_valid = 1'b0;
    logic               o_cmd_ready;
    logic               i_cmd_rst = 1'b0;
    logic               i_cmd_ir = 1'b0;
    logic [LEN_W-1:0]   i_cmd_len = '0;
    logic [MAX_LEN-1:0] i_cmd_data = '0;
    logic               o_rsp_valid;
    logic [MAX_LEN-1:0] o_rsp_data;
    logic               o_busy;
    logic               o_tck;
    logic               o_tms;
    logic               o_tdi;
    logic               i_tdo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtag_drv #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_rst(i_cmd_rst), .i_cmd_ir(i_cmd_ir),
        .i_cmd_len(i_cmd_len), .i_cmd_data(i_cmd_data),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_busy(o_busy),
        .o_tck(o_tck), .o_tms(o_tms), .o_tdi(o_tdi), .i_tdo(i_tdo)
    );

    // Behavioural TAP device: IEEE 1149.1 state graph, BYPASS DR, 4-bit IR capturing 0001.
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    tap_t       tap_st = TLR;
    logic       bypass = 1'b0;
    logic [3:0] ir_sh = 4'h0;
    logic [3:0] ir = 4'hF;
    logic       tdo = 1'b0;
    bit         mon_tms[$];
    bit         mon_tdi[$];

    assign i_tdo = tdo;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            UPIR:  return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge o_tck) begin
        mon_tms.push_back(o_tms);
        mon_tdi.push_back(o_tdi);
        case (tap_st)
            TLR:   ir = 4'hF;
            CAPDR: bypass = 1'b0;
            SHDR:  bypass = o_tdi;
            CAPIR: ir_sh = 4'b0001;
            SHIR:  ir_sh = {o_tdi, ir_sh[3:1]};
            UPIR:  ir = ir_sh;
            default: ;
        endcase
        tap_st = tap_next(tap_st, o_tms);
    end

    always @(negedge o_tck) begin
        tdo = (tap_st == SHDR) ? bypass : (tap_st == SHIR) ? ir_sh[0] : 1'b0;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int clamp_len(int len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    function automatic logic [255:0] mask_of(int lc);
        return (lc >= 256) ? {256{1'b1}} : ((256'd1 << lc) - 256'd1);
    endfunction

    // BYPASS DR: first captured bit is the 0 loaded at Capture-DR, then TDI delayed one TCK.
    function automatic logic [255:0] exp_dr(int len, logic [255:0] d);
        return (d << 1) & mask_of(clamp_len(len));
    endfunction

    // IR: four capture bits 0001 come out first, then TDI delayed four TCKs.
    function automatic logic [255:0] exp_ir(int len, logic [255:0] d);
        return ((d << 4) | 256'd1) & mask_of(clamp_len(len));
    endfunction

    task automatic start_cmd(input logic rst, input logic irs, input int len, input logic [255:0] d);
        int n = 0;
        i_cmd_valid = 1'b1;
        i_cmd_rst   = rst;
        i_cmd_ir    = irs;
        i_cmd_len   = LEN_W'(len);
        i_cmd_data  = d;
        while (!o_cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", o_cmd_ready, 1);
        mon_tms.delete();
        mon_tdi.delete();
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input logic rst, input logic irs, input int len,
                              input logic [255:0] d, input logic [255:0] exp_data);
        bit e_tms[$];
        bit e_tdi[$];
        int lc = clamp_len(len);
        int n;
        int cyc = 1;
        bit hs_bad = 0;
        bit seq_ok = 1;
        if (rst) begin
            e_tms = '{1, 1, 1, 1, 1, 0};
            e_tdi = '{0, 0, 0, 0, 0, 0};
        end else if (lc > 0) begin
            if (irs) e_tms = '{1, 1, 0, 0};
            else     e_tms = '{1, 0, 0};
            for (int i = 0; i < e_tms.size(); i++) e_tdi.push_back(0);
            for (int k = 0; k < lc; k++) begin
                e_tms.push_back(k == lc - 1);
                e_tdi.push_back(d[k]);
            end
            e_tms.push_back(1); e_tdi.push_back(0);
            e_tms.push_back(0); e_tdi.push_back(0);
        end
        n = e_tms.size();
        while (!o_rsp_valid && cyc < 4000) begin
            if (!o_busy || o_cmd_ready) hs_bad = 1;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 2 * DIV * n + 1);
        chk("busy_in_rsp", o_busy, 1);
        chk("ready_low_while_busy", hs_bad | o_cmd_ready, 0);
        chk("rsp_data", o_rsp_data, exp_data);
        chk("tck_low_at_rsp", o_tck, 0);
        chk("tck_count", mon_tms.size(), n);
        if (mon_tms.size() == n) begin
            for (int i = 0; i < n; i++)
                if (mon_tms[i] != e_tms[i] || mon_tdi[i] != e_tdi[i]) seq_ok = 0;
        end else begin
            seq_ok = 0;
        end
        chk("tms_tdi_seq", seq_ok, 1);
        chk("tap_in_rti", (tap_st == RTI), 1);
        @(negedge clk);
        chk("rsp_one_cycle", o_rsp_valid, 0);
        chk("ready_after_rsp", o_cmd_ready, 1);
        chk("rsp_held", o_rsp_data, exp_data);
    endtask

    task automatic run_cmd(input logic rst, input logic irs, input int len,
                           input logic [255:0] d, input logic [255:0] exp_data);
        start_cmd(rst, irs, len, d);
        finish_cmd(rst, irs, len, d, exp_data);
    endtask

    initial begin
        logic [255:0] d;
        logic [255:0] d2;
        int len;
        int len2;
        int n;
        bit quiet;

        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tck", o_tck, 0);
        chk("rst_tms", o_tms, 1);
        chk("rst_tdi", o_tdi, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_data", o_rsp_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_cmd_ready, 1);

        // Reset command (6 TCKs, latency 25 with DIV=2).
        run_cmd(1'b1, 1'b0, 0, 256'hABCD, 256'd0);

        // BYPASS DR scan.
        run_cmd(1'b0, 1'b0, 8, 256'h3C, 256'h78);

        // IR scan writing BYPASS.
        run_cmd(1'b0, 1'b1, 4, 256'hF, 256'h1);
        chk("ir_after_update", ir, 4'hF);

        // Empty scan, then an over-long scan clamped to MAX_LEN.
        run_cmd(1'b0, 1'b0, 0, 256'hFF, 256'd0);
        d = rnd256();
        run_cmd(1'b0, 1'b0, 300, d, exp_dr(300, d));

        // Second command held valid during a scan.
        d  = rnd256();
        d2 = rnd256();
        start_cmd(1'b0, 1'b0, 16, d);
        i_cmd_valid = 1'b1;
        i_cmd_rst   = 1'b0;
        i_cmd_ir    = 1'b0;
        i_cmd_len   = LEN_W'(10);
        i_cmd_data  = d2;
        finish_cmd(1'b0, 1'b0, 16, d, exp_dr(16, d));
        run_cmd(1'b0, 1'b0, 10, d2, exp_dr(10, d2));

        // Randomized DR scans in BYPASS.
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 40);
            d = rnd256();
            run_cmd(1'b0, 1'b0, len, d, exp_dr(len, d));
        end

        // Randomized IR scans, each followed by restoring BYPASS.
        for (int t = 0; t < 2; t++) begin
            len = $urandom_range(4, 12);
            d = rnd256();
            run_cmd(1'b0, 1'b1, len, d, exp_ir(len, d));
            chk("ir_random_update", ir, (d >> (len - 4)) & 256'hF);
            run_cmd(1'b0, 1'b1, 4, 256'hF, 256'h1);
        end

        // Reset asserted during shift TCK 5 of a 64-bit DR scan.
        d = rnd256() & mask_of(64);
        start_cmd(1'b0, 1'b0, 64, d);
        n = 0;
        while (mon_tms.size() < 9 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_shift_tck5", mon_tms.size(), 9);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_tck", o_tck, 0);
        chk("abort_tms", o_tms, 1);
        chk("abort_tdi", o_tdi, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_rsp_valid", o_rsp_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", o_cmd_ready, 1);
        quiet = 1;
        len2 = mon_tms.size();
        repeat (20) begin
            if (o_tck || o_rsp_valid) quiet = 0;
            @(negedge clk);
        end
        chk("idle_after_abort", quiet && (mon_tms.size() == len2), 1);
        run_cmd(1'b1, 1'b0, 0, 256'd0, 256'd0);
        run_cmd(1'b0, 1'b0, 64, d, exp_dr(64, d));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
